// File: rtl/fir_mem_engine.sv
// Memory-mapped FIR engine: reads samples from RAM, convolves with NTAPS programmable taps, writes results back.
// Define FIR_SAT_EN to saturate results to DW bits; otherwise the shifted result wraps.
module fir_mem_engine #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int AW    = 10,
  parameter int NTAPS = 5,
  parameter int SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              input_addr,
  input  logic [AW-1:0]              output_addr,
  input  logic [AW-1:0]              sample_count,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]       coef_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [AW-1:0]              mem_rd_addr,
  input  logic signed [DW-1:0]       mem_rd_data,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_wr_addr,
  output logic signed [DW-1:0]       mem_wr_data
);

  localparam int KW   = $clog2(NTAPS);
  localparam int PW   = DW + CW;
  localparam int ACCW = PW + KW;
  localparam logic [KW-1:0] KLAST = KW'(NTAPS - 1);

`ifdef FIR_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_DRAIN = 3'd2,
    S_WR    = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]          k_q, k_d;
  logic [AW-1:0]          n_q, n_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   vld_p1_q, vld_p1_d;
  logic [KW-1:0]          k_p1_q, k_p1_d;
  logic [AW-1:0]          in_base_q, in_base_d;
  logic [AW-1:0]          out_base_q, out_base_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [CW-1:0]   coef_q [NTAPS];
  logic signed [CW-1:0]   coef_d [NTAPS];
  logic signed [PW-1:0]   prod_p1;
  logic                   rd_hit;
  logic                   last_smp;
  logic                   coef_addr_ok;

  function automatic logic signed [DW-1:0] fmt_result(input logic signed [ACCW-1:0] acc);
`ifdef FIR_SAT_EN
    logic signed [ACCW-1:0] sh;
    sh = acc >>> SHIFT;
    if (sh > SAT_MAX) return DW'(SAT_MAX);
    if (sh < SAT_MIN) return DW'(SAT_MIN);
    return DW'(sh);
`else
    return DW'(acc >>> SHIFT);
`endif
  endfunction

  assign rd_hit       = (state_q == S_RD) && (AW'(k_q) <= n_q);
  assign last_smp     = (n_q == cnt_q - AW'(1));
  assign coef_addr_ok = ({1'b0, coef_addr} < (KW+1)'(NTAPS));

  // Stage p1: read data returns one cycle after the address; multiply by the tap it belongs to
  always_comb begin
    prod_p1 = mem_rd_data * coef_q[k_p1_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (sample_count == '0) ? S_FIN : S_RD;
      S_RD:    if (k_q == KLAST) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WR;
      S_WR:    state_d = last_smp ? S_FIN : S_RD;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_we      = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (rd_hit) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = in_base_q + n_q - AW'(k_q);
    end
    if (state_q == S_WR) begin
      mem_we      = 1'b1;
      mem_wr_addr = out_base_q + n_q;
      mem_wr_data = fmt_result(acc_q);
    end
  end

  always_comb begin
    k_d        = k_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    acc_d      = acc_q;
    vld_p1_d   = 1'b0;
    k_p1_d     = k_q;
    coef_d     = coef_q;
    if (vld_p1_q) acc_d = acc_q + ACCW'(prod_p1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_base_d  = input_addr;
          out_base_d = output_addr;
          cnt_d      = sample_count;
          n_d        = '0;
          k_d        = '0;
          acc_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      S_RD: begin
        vld_p1_d = rd_hit;
        k_d      = (k_q == KLAST) ? '0 : k_q + KW'(1);
      end
      S_WR: begin
        if (last_smp) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          n_d   = n_q + AW'(1);
          k_d   = '0;
          acc_d = '0;
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    if (coef_we && !busy_q && coef_addr_ok) coef_d[coef_addr] = coef_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_p1_q <= 1'b0;
      k_p1_q   <= '0;
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= (i == 0) ? CW'(1) : '0;
    end else begin
      k_q      <= k_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vld_p1_q <= vld_p1_d;
      k_p1_q   <= k_p1_d;
      coef_q   <= coef_d;
    end
  end

  // Stage p2: accumulator and latched job bases carry no reset; they are loaded on start
  always_ff @(posedge clk) begin
    in_base_q  <= in_base_d;
    out_base_q <= out_base_d;
    acc_q      <= acc_d;
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fir_mem_engine.sv
// Self-checking bench for fir_mem_engine: directed table, corner sequences and random jobs against a sum-of-products model.
module tb_fir_mem_engine;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int AW   = 10;
  localparam int NT   = 5;
  localparam int SH   = 0;
  localparam int KW   = $clog2(NT);
  localparam int SPAN = NT + 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [AW-1:0]          input_addr, output_addr, sample_count;
  logic                   coef_we;
  logic [KW-1:0]          coef_addr;
  logic signed [CW-1:0]   coef_wdata;
  logic                   busy, done, mem_rd_en, mem_we;
  logic [AW-1:0]          mem_rd_addr, mem_wr_addr;
  logic signed [DW-1:0]   mem_rd_data;
  logic signed [DW-1:0]   mem_wr_data;

  always #5 clk = ~clk;

  fir_mem_engine #(.DW(DW), .CW(CW), .AW(AW), .NTAPS(NT), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_addr(input_addr), .output_addr(output_addr), .sample_count(sample_count),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  logic signed [DW-1:0] mem [1024];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int n_pass = 0;
  int n_chk  = 0;
  int hs[$];
  int xs[$];
  int wlog_a[$];
  int wlog_d[$];

  typedef struct packed {
    logic [9:0]      ia;
    logic [9:0]      oa;
    logic [3:0]      n;
    logic [0:4][7:0] h;
    logic [0:4][7:0] x;
    logic [0:4][7:0] y;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  function automatic int ref_y(input int n);
    int acc = 0;
    int s;
    for (int k = 0; k < NT; k++)
      if (n - k >= 0) acc += xs[n-k] * hs[k];
    s = acc >>> SH;
`ifdef FIR_SAT_EN
    if (s > (1 << (DW-1)) - 1) s = (1 << (DW-1)) - 1;
    if (s < -(1 << (DW-1))) s = -(1 << (DW-1));
`else
    s = s & ((1 << DW) - 1);
    if (s >= (1 << (DW-1))) s -= (1 << DW);
`endif
    return s;
  endfunction

  task automatic write_coef(input int k, input int v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = KW'(k); coef_wdata = CW'(v);
    @(posedge clk);
    #1 coef_we = 1'b0;
    hs[k] = v;
  endtask

  task automatic load_x(input int ia);
    for (int i = 0; i < xs.size(); i++) mem[10'((ia + i) % 1024)] = DW'(xs[i]);
  endtask

  task automatic run_job(input int ia, input int oa, input int n, input bit inject, input string nm);
    int c, done_c, last_we, bad, busy_done, s, k, exp_addr, budget;
    bit exp_en, exp_we;
    done_c = -1; last_we = -1; bad = 0; busy_done = -1;
    budget = n * SPAN + 10;
    wlog_a = {}; wlog_d = {};
    @(negedge clk);
    input_addr = AW'(ia); output_addr = AW'(oa); sample_count = AW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; c = 1;
    while (c <= budget && done_c < 0) begin
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = 0;
      if (c <= n * SPAN) begin
        s = (c - 1) / SPAN; k = (c - 1) % SPAN;
        exp_en = (k < NT) && (k <= s);
        if (exp_en) exp_addr = (ia + s - k) & 1023;
        exp_we = (k == SPAN - 1);
      end
      if (int'(mem_rd_en) != int'(exp_en) || int'(mem_rd_addr) != exp_addr ||
          int'(mem_we) != int'(exp_we)) bad++;
      if (!mem_we && (mem_wr_addr != '0 || mem_wr_data != '0)) bad++;
      if (mem_we) begin
        wlog_a.push_back(int'(mem_wr_addr));
        wlog_d.push_back(int'(mem_wr_data));
        last_we = c;
      end
      if (done) begin done_c = c; busy_done = int'(busy); end
      if (c == 1) chk({nm, "_busy_c1"}, int'(busy), 1);
      if (inject && c == 3) begin
        start = 1'b1; input_addr = AW'(ia ^ 'h155); sample_count = AW'(2);
        coef_we = 1'b1; coef_addr = '0; coef_wdata = CW'(99);
      end
      if (inject && c == 4) begin
        start = 1'b0; input_addr = AW'(ia); sample_count = AW'(n); coef_we = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    chk({nm, "_wcount"}, wlog_a.size(), n);
    for (int i = 0; i < n && i < wlog_a.size(); i++) begin
      chk($sformatf("%s_waddr%0d", nm, i), wlog_a[i], (oa + i) & 1023);
      chk($sformatf("%s_wdata%0d", nm, i), wlog_d[i], ref_y(i));
    end
    chk({nm, "_done_cycle"}, done_c, (n == 0) ? 2 : n * SPAN + 1);
    chk({nm, "_last_we_cycle"}, last_we, (n == 0) ? -1 : n * SPAN);
    chk({nm, "_busy_at_done"}, busy_done, 0);
    chk({nm, "_sched_errs"}, bad, 0);
  endtask

  initial begin
    vec_t v;
    int n, ia, oa, c, traffic;
    rst = 1'b1; start = 1'b0; input_addr = '0; output_addr = '0; sample_count = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    hs = '{1, 0, 0, 0, 0};

    v.ia = 10'h010; v.oa = 10'h200; v.n = 4'd5;
    v.h = {8'd1, 8'd2, 8'd3, 8'd2, 8'd1};
    v.x = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    v.y = {8'd1, 8'd4, 8'd10, 8'd18, 8'd27};
    tbl.push_back(v);
    v.x = {8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
`ifdef FIR_SAT_EN
    v.y = {8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
`else
    v.y = {8'd127, 8'd125, 8'hFA, 8'hF8, 8'h77};
`endif
    tbl.push_back(v);
    v.ia = 10'h040; v.oa = 10'h100; v.n = 4'd3;
    v.h = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    v.x = {8'hFB, 8'd7, 8'h80, 8'd0, 8'd0};
    v.y = {8'hFB, 8'd7, 8'h80, 8'd0, 8'd0};
    tbl.push_back(v);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_rd_addr", int'(mem_rd_addr), 0);
    chk("rst_wr_addr", int'(mem_wr_addr), 0);
    chk("rst_wr_data", int'(mem_wr_data), 0);

    xs = '{-5, 7, -128};
    load_x('h040);
    run_job('h040, 'h100, 3, 1'b0, "ident_rst");

    for (int t = 0; t < tbl.size(); t++) begin
      v = tbl[t];
      for (int k = 0; k < NT; k++) write_coef(k, int'($signed(v.h[3'(k)])));
      xs = {};
      for (int i = 0; i < int'(v.n); i++) xs.push_back(int'($signed(v.x[3'(i)])));
      load_x(int'(v.ia));
      run_job(int'(v.ia), int'(v.oa), int'(v.n), 1'b0, $sformatf("tbl%0d", t));
      for (int i = 0; i < int'(v.n) && i < wlog_d.size(); i++)
        chk($sformatf("tbl%0d_y%0d", t, i), wlog_d[i], int'($signed(v.y[3'(i)])));
    end

    run_job('h080, 'h180, 0, 1'b0, "n_zero");

    write_coef(0, 1); write_coef(1, 2); write_coef(2, 3); write_coef(3, 2); write_coef(4, 1);
    xs = '{10, -20, 30, -40, 50};
    load_x('h020);
    run_job('h020, 'h220, 5, 1'b1, "busy_ignore");

    xs = '{3, -1, 4, -1};
    load_x('h3FE);
    run_job('h3FE, 'h3FF, 4, 1'b0, "wrap");

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
      n = int'($urandom_range(1, 8));
      ia = int'($urandom_range(0, 1023));
      oa = (ia + 512) & 1023;
      xs = {};
      for (int i = 0; i < n; i++) xs.push_back(int'($urandom_range(0, 255)) - 128);
      load_x(ia);
      run_job(ia, oa, n, 1'b0, $sformatf("rand%0d", r));
    end

    write_coef(0, 1); write_coef(1, 2); write_coef(2, 3); write_coef(3, 2); write_coef(4, 1);
    xs = '{1, 2, 3, 4, 5};
    load_x('h010);
    @(negedge clk);
    input_addr = AW'('h010); output_addr = AW'('h200); sample_count = AW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0; c = 1;
    while (c < 21) begin @(negedge clk); c++; end
    chk("midrst_we_before", int'(mem_we), 1);
    rst = 1'b1;
    #1;
    chk("midrst_we_after", int'(mem_we), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_rd_en", int'(mem_rd_en), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    traffic = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_we || mem_rd_en || busy || done) traffic++;
    end
    chk("midrst_quiet", traffic, 0);
    hs = '{1, 0, 0, 0, 0};
    xs = '{-5, 7, -128};
    load_x('h040);
    run_job('h040, 'h100, 3, 1'b0, "ident_after_midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_mem_engine.md
# fir_mem_engine

Parametrised, memory-mapped FIR filter engine: reads `SAMPLE_COUNT` signed samples from a synchronous-read RAM, computes y[n] = Σ h[k]·x[n−k] over `NTAPS` run-time-programmable coefficients, and writes scaled results back through a second RAM port. It is the general-width, general-depth successor to the fixed 5-tap, 8-bit memory FIR and sits between the shared sample RAM and the controller that issues `start`.

## Interface
Parameters:
- `DW`, 8, sample/result width (signed)
- `CW`, 8, coefficient width (signed)
- `AW`, 10, memory address width
- `NTAPS`, 5, number of taps (2..32)
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before output

Ports:
- `clk` in 1 clock
- `rst` in 1 reset, asynchronous, active-high
- `start` in 1 begin a job; sampled only in IDLE
- `input_addr` in AW base address of x[0]
- `output_addr` in AW base address of y[0]
- `sample_count` in AW number of samples N
- `coef_we` in 1 coefficient write strobe
- `coef_addr` in clog2(NTAPS) tap index k
- `coef_wdata` in CW signed value for h[k]
- `busy` out 1 high from the cycle after `start` is accepted until `done` rises
- `done` out 1 level; high after job completes, cleared when the next `start` is accepted
- `mem_rd_en` out 1 read strobe
- `mem_rd_addr` out AW read address
- `mem_rd_data` in DW read data, valid exactly 1 cycle after `mem_rd_en`
- `mem_we` out 1 write strobe
- `mem_wr_addr` out AW write address
- `mem_wr_data` out DW result

## Operation
- States: IDLE → RD → DRAIN → WR → (RD | FIN) → IDLE.
- IDLE: `start`=1 latches `input_addr`, `output_addr`, `sample_count`, sets n=0, k=0, clears `done`, clears the accumulator. If `sample_count`=0 go to FIN (no memory traffic), else RD.
- RD (NTAPS cycles, k=0..NTAPS−1): drive `mem_rd_addr`=input_addr+n−k (mod 2^AW); `mem_rd_en`=1 only when k≤n. A tap-valid flag and k are delayed one cycle; the delayed product mem_rd_data·h[k] is added to the accumulator only when its flag is set (taps with n−k<0 contribute zero). After k=NTAPS−1 go to DRAIN.
- DRAIN (1 cycle): accumulates the last outstanding tap.
- WR (1 cycle): `mem_we`=1, `mem_wr_addr`=output_addr+n (mod 2^AW), `mem_wr_data`=formatted result. If n=N−1 go to FIN, else n←n+1, k←0, accumulator←0, go to RD.
- FIN (1 cycle): `done`←1, → IDLE.
- Arithmetic: product DW+CW bits signed; accumulator ACCW = DW+CW+clog2(NTAPS) bits signed, no internal overflow possible. Result = acc >>> SHIFT, then reduced to DW bits per Configuration.
- Coefficients: `coef_we` writes h[coef_addr] in any cycle while `busy`=0; ignored while `busy`=1; `coef_addr` ≥ NTAPS ignored. Reset value: h[0]=1, all others 0 (identity filter).
- `start` while busy: ignored. In-place operation (overlapping input/output regions) is not supported; result is undefined.
- `rst` mid-job: immediate return to IDLE, job abandoned, no further writes.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_we`=0, all address/data outputs 0, coefficients as above.
- Cycle 0 = `start` accepted. Sample n occupies NTAPS+2 cycles: RD at cycles 1+n(NTAPS+2) … NTAPS+n(NTAPS+2), DRAIN next, WR at (n+1)(NTAPS+2).
- Last WR at N(NTAPS+2); `done` high and `busy` low from cycle N(NTAPS+2)+1. N=0: `done` at cycle 2.
- `mem_rd_en`/`mem_we` never asserted in the same cycle; address/data outputs are 0 whenever their strobe is low.

## Configuration
- `FIR_SAT_EN` defined: shifted result saturates to [−2^(DW−1), 2^(DW−1)−1].
- `FIR_SAT_EN` undefined: shifted result truncated to its low DW bits (wrap).

## Test plan
- Defaults, h={1,2,3,2,1}, x=1,2,3,4,5 at input_addr=0x010, output_addr=0x200, N=5 -> writes 1,4,10,18,27 to 0x200..0x204; last `mem_we` at cycle 35, `done` at 36.
- Same setup, x all 127, check y[4]: with `FIR_SAT_EN` -> 127; without -> 0x77 (1143 mod 256); y[0] = 127 both.
- After reset without coefficient writes, x=−5,7,−128 -> y = −5,7,−128 (identity); SHIFT=2 build with h={4,0,0,0,0} -> same outputs.
- `sample_count`=0 -> no `mem_rd_en`/`mem_we`, `done` at cycle 2; `coef_we` and second `start` during a busy job -> both ignored, outputs unchanged.
- input_addr=0x3FE, N=4, output_addr=0x3FF -> reads wrap to 0x000/0x001, writes to 0x3FF,0x000,0x001,0x002.
- Assert `rst` during WR of sample 2 -> `mem_we` drops the same cycle, no further writes, `busy`=`done`=0, h reset to identity.
